rcpu_bus_unit: RTL and testbench
================================

Name: rcpu_bus_unit

Overview:
- Parametrised memory bus unit between the RCPU core and a variable-latency memory.
- Replaces the fixed single-cycle PC/A/ALU/SP address mux with CH request channels (fetch, data, stack, ...).
- Arbitrates between channels using fixed-priority or round-robin mode.
- Runs a req/ack handshake to memory with an optional timeout, and returns per-channel done/err pulses the controller uses to stall.

Parameters:
- M, 16, data/address bus width.
- CH, 3, number of request channels (1..8).
- RR, 0, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- TIMEOUT, 0, max cycles to wait for mem_ack; 0 disables timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ch_req  in  CH  per-channel request, held high until that channel's done.
- ch_we  in  CH  per-channel write enable (1 = write).
- ch_addr  in  CH*M  per-channel address; channel i uses bits [i*M +: M].
- ch_wdata  in  CH*M  per-channel write data, same packing as ch_addr.
- ch_done  out  CH  one-cycle completion pulse for the granted channel.
- ch_err  out  1  one-cycle pulse with ch_done when the transfer timed out.
- rdata  out  M  read data, valid in the ch_done cycle; held until the next completion.
- busy  out  1  high while a transfer is outstanding.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  memory write enable, qualified by mem_req.
- mem_addr  out  M  memory address.
- mem_wdata  out  M  memory write data.
- mem_rdata  in  M  memory read data, sampled on the mem_ack cycle.
- mem_ack  in  1  memory completion, one cycle.

Behaviour:
- Reset values (synchronous, active-high): state IDLE; mem_req, mem_we, busy, ch_done, ch_err = 0; mem_addr, mem_wdata, rdata = 0; RR pointer = 0; timeout counter = 0.
- Reset mid-transfer aborts the transfer: no done pulse is produced; mem_req drops the cycle after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any ch_req is high, select a grant index g.
  - Latch ch_addr[g], ch_wdata[g], ch_we[g] into mem_addr/mem_wdata/mem_we.
  - Set mem_req = 1 and busy = 1; go to ACCESS.
  - No requests: stay in IDLE with outputs unchanged, except mem_req = 0.
- ACCESS:
  - mem_ack = 1: latch rdata = mem_rdata for reads (rdata unchanged on writes); drop mem_req; go to RESP.
  - TIMEOUT > 0 and counter == TIMEOUT-1 without ack: set rdata = 0; flag error; drop mem_req; go to RESP.
  - Otherwise increment the counter.
- RESP:
  - ch_done[g] = 1 for exactly one cycle; ch_err = 1 in the same cycle if the transfer timed out.
  - Clear busy and the counter; return to IDLE.
  - RESP is a mandatory turnaround cycle: a new grant happens no earlier than the cycle after RESP.
- Minimum latency: request sampled at cycle t → mem_req high at t+1 → ack at t+1 → ch_done at t+2. Throughput is at most one transfer per 3 cycles.
- Arbitration:
  - RR=0: lowest index with ch_req high wins.
  - RR=1: search starts at the pointer and wraps modulo CH; after each grant the pointer becomes (g+1) mod CH.
- Address, data and we are latched at grant. Later changes to ch_* inputs, or ch_req dropping, do not affect the transfer in flight; done is still pulsed.
- mem_ack while not in ACCESS is ignored.
- An ack in the timeout cycle wins over the timeout: normal completion, no error.
- CH=1 degenerates to a pass-through with handshake; the pointer is constant 0.

Decomposition:
- Shared constants package (extend the existing constants include):
  - Bus-unit state encodings: BU_IDLE, BU_ACCESS, BU_RESP.
  - Channel index names: CH_FETCH = 0, CH_DATA = 1, CH_STACK = 2.
- One natural sub-module: rcpu_arbiter. Parametrised by CH and RR; combinational request→one-hot grant plus the registered RR pointer with an advance input.
- The FSM, latches and timeout counter stay in rcpu_bus_unit.

Test Plan:
- Single read: ch_req=3'b001, ch_addr[0]=16'h0040, mem_rdata=16'hBEEF with ack 1 cycle after mem_req → mem_addr=16'h0040, mem_we=0, ch_done=3'b001 at t+2, rdata=16'hBEEF.
- Priority, RR=0: ch_req=3'b110 held → channel 1 completes first, then channel 2; ch_done pulses 3'b010 then 3'b100; channel 2's mem_req appears the cycle after channel 1's RESP.
- Round-robin, RR=1: all three requests held for 3 transfers, immediate ack → grant order 0,1,2; re-raising all three after that → next grant is 0.
- Write with wait states: ch_we[1]=1, ch_addr=16'h1234, ch_wdata=16'h00FF, ack after 4 cycles → mem_req high for 4 cycles with stable address/data; ch_done=3'b010; rdata unchanged.
- Timeout: TIMEOUT=5, no ack → mem_req drops after 5 cycles; ch_done and ch_err pulse together; rdata=0; a later stray mem_ack is ignored.
- Reset mid-ACCESS: rst high for 1 cycle during the wait → no ch_done; mem_req=0 and busy=0 from the next cycle; the RR pointer returns to 0.

Source files
------------

// File: rtl/rcpu_bus_unit_pkg.sv
// Shared constants for the RCPU memory bus unit: FSM encodings and channel names.
package rcpu_bus_unit_pkg;

   // Bus-unit sequencer states
   typedef enum logic [1:0] {
      BU_IDLE   = 2'd0,
      BU_ACCESS = 2'd1,
      BU_RESP   = 2'd2
   } bu_state_e;

   // Conventional request channel indices used by the RCPU controller
   localparam int CH_FETCH = 0;
   localparam int CH_DATA  = 1;
   localparam int CH_STACK = 2;

   // Next round-robin start position after granting idx among n channels
   function automatic int rr_next(input int idx, input int n);
      int nxt;
      nxt = 0;
      if (idx >= n - 1) begin
         nxt = 0;
      end else begin
         nxt = idx + 1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/rcpu_arbiter.sv
// Request arbiter: combinational request -> grant, fixed priority or round-robin.
// The round-robin start pointer is registered and moves past the winner on advance.
module rcpu_arbiter
   import rcpu_bus_unit_pkg::*;
#(
   parameter int CH = 3,
   parameter int RR = 0,
   localparam int IW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] req,
   input  logic          advance,
   output logic          any_req,
   output logic [IW-1:0] grant_idx,
   output logic [CH-1:0] grant_oh
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;

   // Pick the first requester, searching from 0 (fixed) or from the pointer (round-robin)
   always_comb begin
      int  cand;
      logic found;
      cand      = 0;
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < CH; k++) begin
         if (RR != 0) begin
            cand = (int'(ptr_q) + k) % CH;
         end else begin
            cand = k;
         end
         if (!found && req[cand]) begin
            found     = 1'b1;
            grant_idx = IW'(cand);
         end else begin
            found = found;
         end
      end
      any_req = found;
   end

   // One-hot form of the winning index
   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < CH; i++) begin
         grant_oh[i] = any_req && (grant_idx == IW'(i));
      end
   end

   // Pointer moves just past the winner on each accepted grant; constant 0 otherwise
   always_comb begin
      ptr_d = ptr_q;
      if ((RR != 0) && (CH > 1) && advance) begin
         ptr_d = IW'(rr_next(int'(grant_idx), CH));
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rcpu_bus_unit.sv
// RCPU memory bus unit: arbitrates CH request channels onto one req/ack memory port,
// with optional timeout, and returns per-channel done/err pulses for controller stalls.
module rcpu_bus_unit
   import rcpu_bus_unit_pkg::*;
#(
   parameter int M       = 16,
   parameter int CH      = 3,
   parameter int RR      = 0,
   parameter int TIMEOUT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CH-1:0]   ch_req,
   input  logic [CH-1:0]   ch_we,
   input  logic [CH*M-1:0] ch_addr,
   input  logic [CH*M-1:0] ch_wdata,
   output logic [CH-1:0]   ch_done,
   output logic            ch_err,
   output logic [M-1:0]    rdata,
   output logic            busy,
   output logic            mem_req,
   output logic            mem_we,
   output logic [M-1:0]    mem_addr,
   output logic [M-1:0]    mem_wdata,
   input  logic [M-1:0]    mem_rdata,
   input  logic            mem_ack
);

   localparam int IW = (CH > 1) ? $clog2(CH) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   bu_state_e       state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [M-1:0]    mem_addr_q, mem_addr_d;
   logic [M-1:0]    mem_wdata_q, mem_wdata_d;
   logic [M-1:0]    rdata_q, rdata_d;
   logic            busy_q, busy_d;
   logic [CH-1:0]   ch_done_q, ch_done_d;
   logic            ch_err_q, ch_err_d;
   logic [CH-1:0]   gnt_q, gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            any_req_s;
   logic [IW-1:0]   grant_idx_s;
   logic [CH-1:0]   grant_oh_s;
   logic            advance_s;

   // The pointer only moves when a grant is actually taken in IDLE
   assign advance_s = (state_q == BU_IDLE) && any_req_s;

   rcpu_arbiter #(
      .CH (CH),
      .RR (RR)
   ) u_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req       (ch_req),
      .advance   (advance_s),
      .any_req   (any_req_s),
      .grant_idx (grant_idx_s),
      .grant_oh  (grant_oh_s)
   );

   // Sequencer next-state: grant/latch in IDLE, wait for ack or timeout, one turnaround cycle
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      busy_d      = busy_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      ch_done_d   = '0;
      ch_err_d    = 1'b0;
      case (state_q)
         BU_IDLE: begin
            if (any_req_s) begin
               mem_addr_d  = ch_addr[int'(grant_idx_s)*M +: M];
               mem_wdata_d = ch_wdata[int'(grant_idx_s)*M +: M];
               mem_we_d    = ch_we[grant_idx_s];
               gnt_d       = grant_oh_s;
               mem_req_d   = 1'b1;
               busy_d      = 1'b1;
               cnt_d       = '0;
               state_d     = BU_ACCESS;
            end else begin
               mem_req_d = 1'b0;
            end
         end
         BU_ACCESS: begin
            if (mem_ack) begin
               // Ack wins even in the timeout cycle
               if (!mem_we_q) begin
                  rdata_d = mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
               mem_req_d = 1'b0;
               ch_done_d = gnt_q;
               state_d   = BU_RESP;
            end else if ((TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
               rdata_d   = '0;
               ch_err_d  = 1'b1;
               ch_done_d = gnt_q;
               mem_req_d = 1'b0;
               state_d   = BU_RESP;
            end else if (TIMEOUT > 0) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         BU_RESP: begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = BU_IDLE;
         end
         default: begin
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            cnt_d     = '0;
            state_d   = BU_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transfer without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BU_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         ch_done_q   <= '0;
         ch_err_q    <= 1'b0;
         gnt_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         ch_done_q   <= ch_done_d;
         ch_err_q    <= ch_err_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ch_done   = ch_done_q;
   assign ch_err    = ch_err_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rcpu_bus_unit.sv
// Scoreboard bench for rcpu_bus_unit: a fixed-priority unit with TIMEOUT=5 (a_*)
// and a round-robin unit without timeout (b_*), each driven by a small memory model.
module tb_rcpu_bus_unit;
   import rcpu_bus_unit_pkg::*;

   typedef struct packed {
      logic [2:0]  done;
      logic        err;
      logic [15:0] rdata;
   } done_t;

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
   } mem_t;

   logic clk;
   logic rst;

   logic [2:0]  a_req, a_we, a_done;
   logic [47:0] a_addr, a_wdata;
   logic        a_err, a_busy, a_mreq, a_mwe, a_mack;
   logic [15:0] a_rdata, a_maddr, a_mwdata, a_mrdata;

   logic [2:0]  b_req, b_we, b_done;
   logic [47:0] b_addr, b_wdata;
   logic        b_err, b_busy, b_mreq, b_mwe, b_mack;
   logic [15:0] b_rdata, b_maddr, b_mwdata, b_mrdata;

   int          lat_a, lat_b, wcnt_a, wcnt_b;
   logic        stray_a;
   logic [15:0] rdbase_a, rdbase_b;

   done_t exp_done_a[$];
   done_t exp_done_b[$];
   mem_t  exp_mem_a[$];
   mem_t  exp_mem_b[$];

   int n_checks;
   int n_pass;

   rcpu_bus_unit #(.M(16), .CH(3), .RR(0), .TIMEOUT(5)) dut_a (
      .clk(clk), .rst(rst), .ch_req(a_req), .ch_we(a_we), .ch_addr(a_addr),
      .ch_wdata(a_wdata), .ch_done(a_done), .ch_err(a_err), .rdata(a_rdata),
      .busy(a_busy), .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr),
      .mem_wdata(a_mwdata), .mem_rdata(a_mrdata), .mem_ack(a_mack)
   );

   rcpu_bus_unit #(.M(16), .CH(3), .RR(1), .TIMEOUT(0)) dut_b (
      .clk(clk), .rst(rst), .ch_req(b_req), .ch_we(b_we), .ch_addr(b_addr),
      .ch_wdata(b_wdata), .ch_done(b_done), .ch_err(b_err), .rdata(b_rdata),
      .busy(b_busy), .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr),
      .mem_wdata(b_mwdata), .mem_rdata(b_mrdata), .mem_ack(b_mack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model A: ack after lat_a request cycles (0 = never), optional stray ack when idle
   initial begin
      a_mack = 1'b0;
      a_mrdata = 16'h0000;
      wcnt_a = 0;
      forever begin
         @(posedge clk);
         #2;
         a_mack = 1'b0;
         if (a_mreq) begin
            if (lat_a != 0 && wcnt_a == lat_a - 1) begin
               a_mack = 1'b1;
               a_mrdata = rdbase_a ^ a_maddr;
               wcnt_a = 0;
            end else begin
               wcnt_a = wcnt_a + 1;
            end
         end else begin
            wcnt_a = 0;
            if (stray_a) begin
               a_mack = 1'b1;
               a_mrdata = 16'h7777;
            end
         end
      end
   end

   // Memory model B
   initial begin
      b_mack = 1'b0;
      b_mrdata = 16'h0000;
      wcnt_b = 0;
      forever begin
         @(posedge clk);
         #2;
         b_mack = 1'b0;
         if (b_mreq) begin
            if (lat_b != 0 && wcnt_b == lat_b - 1) begin
               b_mack = 1'b1;
               b_mrdata = rdbase_b ^ b_maddr;
               wcnt_b = 0;
            end else begin
               wcnt_b = wcnt_b + 1;
            end
         end else begin
            wcnt_b = 0;
         end
      end
   end

   // Monitor: compare every accepted memory request and every done pulse with the queues
   initial begin
      done_t d;
      mem_t  m;
      forever begin
         @(negedge clk);
         if (a_mreq && a_mack) begin
            if (exp_mem_a.size() == 0) begin
               check("a_mem_unexpected", 32'(a_maddr), 32'hFFFF_FFFF);
            end else begin
               m = exp_mem_a.pop_front();
               check("a_mem_addr", 32'(a_maddr), 32'(m.addr));
               check("a_mem_we", 32'(a_mwe), 32'(m.we));
               check("a_mem_wdata", 32'(a_mwdata), 32'(m.wdata));
            end
         end
         if (b_mreq && b_mack) begin
            if (exp_mem_b.size() == 0) begin
               check("b_mem_unexpected", 32'(b_maddr), 32'hFFFF_FFFF);
            end else begin
               m = exp_mem_b.pop_front();
               check("b_mem_addr", 32'(b_maddr), 32'(m.addr));
               check("b_mem_we", 32'(b_mwe), 32'(m.we));
            end
         end
         if (a_done != 3'b000) begin
            if (exp_done_a.size() == 0) begin
               check("a_done_unexpected", 32'(a_done), 32'h0);
            end else begin
               d = exp_done_a.pop_front();
               check("a_done", 32'(a_done), 32'(d.done));
               check("a_err", 32'(a_err), 32'(d.err));
               check("a_rdata", 32'(a_rdata), 32'(d.rdata));
            end
         end
         if (b_done != 3'b000) begin
            if (exp_done_b.size() == 0) begin
               check("b_done_unexpected", 32'(b_done), 32'h0);
            end else begin
               d = exp_done_b.pop_front();
               check("b_done", 32'(b_done), 32'(d.done));
               check("b_err", 32'(b_err), 32'(d.err));
               check("b_rdata", 32'(b_rdata), 32'(d.rdata));
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      n_checks = 0;
      n_pass = 0;
      rst = 1'b1;
      a_req = 3'b000; a_we = 3'b000; a_addr = 48'h0; a_wdata = 48'h0;
      b_req = 3'b000; b_we = 3'b000; b_addr = 48'h0; b_wdata = 48'h0;
      lat_a = 1; lat_b = 1; stray_a = 1'b0;
      rdbase_a = 16'h0000; rdbase_b = 16'h0000;
      tick();
      tick();
      check("rst_mem_req", 32'(a_mreq), 32'h0);
      check("rst_busy", 32'(a_busy), 32'h0);
      check("rst_done_err", 32'({a_done, a_err}), 32'h0);
      check("rst_addr_data", 32'({a_maddr, a_rdata}), 32'h0);
      check("rst_we_wdata", 32'({a_mwe, a_mwdata}), 32'h0);
      check("rst_b_busy", 32'({b_busy, b_mreq}), 32'h0);

      // Single read on the fetch channel, minimum latency
      rst = 1'b0;
      lat_a = 1;
      rdbase_a = 16'hBEAF;
      a_addr[CH_FETCH*16 +: 16] = 16'h0040;
      a_req = 3'b001;
      exp_mem_a.push_back('{addr: 16'h0040, we: 1'b0, wdata: 16'h0000});
      exp_done_a.push_back('{done: 3'b001, err: 1'b0, rdata: 16'hBEEF});
      tick();
      check("t1_mem_req", 32'(a_mreq), 32'h1);
      check("t1_mem_addr", 32'(a_maddr), 32'h0040);
      check("t1_busy", 32'(a_busy), 32'h1);
      tick();
      check("t1_done_t2", 32'(a_done), 32'h1);
      check("t1_mem_req_drop", 32'(a_mreq), 32'h0);
      a_req = 3'b000;
      tick();
      check("t1_busy_clear", 32'(a_busy), 32'h0);

      // Fixed priority: channel 1 before channel 2, one turnaround between them
      rdbase_a = 16'h1111;
      a_addr[CH_DATA*16 +: 16] = 16'h0100;
      a_addr[CH_STACK*16 +: 16] = 16'h0200;
      a_req = 3'b110;
      exp_mem_a.push_back('{addr: 16'h0100, we: 1'b0, wdata: 16'h0000});
      exp_mem_a.push_back('{addr: 16'h0200, we: 1'b0, wdata: 16'h0000});
      exp_done_a.push_back('{done: 3'b010, err: 1'b0, rdata: 16'h1011});
      exp_done_a.push_back('{done: 3'b100, err: 1'b0, rdata: 16'h1311});
      tick();
      check("t2_first_addr", 32'(a_maddr), 32'h0100);
      tick();
      a_req = 3'b100;
      tick();
      check("t2_turnaround_idle", 32'(a_mreq), 32'h0);
      tick();
      check("t2_second_req", 32'(a_mreq), 32'h1);
      check("t2_second_addr", 32'(a_maddr), 32'h0200);
      tick();
      a_req = 3'b000;
      tick();

      // Write with 4 wait states; inputs change mid-transfer but the latched values hold
      lat_a = 4;
      a_we = 3'b010;
      a_addr[CH_DATA*16 +: 16] = 16'h1234;
      a_wdata[CH_DATA*16 +: 16] = 16'h00FF;
      a_req = 3'b010;
      exp_mem_a.push_back('{addr: 16'h1234, we: 1'b1, wdata: 16'h00FF});
      exp_done_a.push_back('{done: 3'b010, err: 1'b0, rdata: 16'h1311});
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_req_held", 32'(a_mreq), 32'h1);
         check("t3_addr_stable", 32'(a_maddr), 32'h1234);
         check("t3_wdata_stable", 32'({a_mwe, a_mwdata}), 32'h100FF);
         if (i == 0) begin
            a_addr[CH_DATA*16 +: 16] = 16'hDEAD;
            a_wdata[CH_DATA*16 +: 16] = 16'h0000;
         end
      end
      tick();
      check("t3_req_drop", 32'(a_mreq), 32'h0);
      a_req = 3'b000;
      a_we = 3'b000;
      tick();

      // Timeout: no ack, request held 5 cycles, then done+err with rdata cleared
      lat_a = 0;
      a_addr[CH_FETCH*16 +: 16] = 16'h0044;
      a_req = 3'b001;
      exp_done_a.push_back('{done: 3'b001, err: 1'b1, rdata: 16'h0000});
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_req_waiting", 32'(a_mreq), 32'h1);
      end
      tick();
      check("t4_req_dropped", 32'(a_mreq), 32'h0);
      check("t4_err_pulse", 32'({a_done, a_err}), 32'b0011);
      a_req = 3'b000;
      tick();
      check("t4_busy_clear", 32'(a_busy), 32'h0);
      stray_a = 1'b1;
      tick();
      stray_a = 1'b0;
      tick();
      tick();
      check("t4_stray_rdata", 32'(a_rdata), 32'h0);
      check("t4_stray_idle", 32'({a_busy, a_mreq}), 32'h0);

      // Round-robin: all held gives 0,1,2; re-raised after that restarts at 0
      lat_b = 1;
      rdbase_b = 16'h0F0F;
      b_addr[CH_FETCH*16 +: 16] = 16'h0A00;
      b_addr[CH_DATA*16 +: 16] = 16'h0B00;
      b_addr[CH_STACK*16 +: 16] = 16'h0C00;
      b_req = 3'b111;
      exp_mem_b.push_back('{addr: 16'h0A00, we: 1'b0, wdata: 16'h0000});
      exp_mem_b.push_back('{addr: 16'h0B00, we: 1'b0, wdata: 16'h0000});
      exp_mem_b.push_back('{addr: 16'h0C00, we: 1'b0, wdata: 16'h0000});
      exp_done_b.push_back('{done: 3'b001, err: 1'b0, rdata: 16'h050F});
      exp_done_b.push_back('{done: 3'b010, err: 1'b0, rdata: 16'h040F});
      exp_done_b.push_back('{done: 3'b100, err: 1'b0, rdata: 16'h030F});
      for (int i = 0; i < 8; i++) begin
         tick();
      end
      b_req = 3'b000;
      tick();
      tick();
      b_req = 3'b111;
      exp_mem_b.push_back('{addr: 16'h0A00, we: 1'b0, wdata: 16'h0000});
      exp_done_b.push_back('{done: 3'b001, err: 1'b0, rdata: 16'h050F});
      tick();
      check("rr_restart_grant0", 32'(b_maddr), 32'h0A00);
      tick();
      b_req = 3'b000;
      tick();

      // Reset mid-ACCESS: pointer is at 1, transfer aborted, pointer back to 0
      lat_b = 0;
      b_req = 3'b111;
      tick();
      check("rst_pre_grant1", 32'(b_maddr), 32'h0B00);
      tick();
      rst = 1'b1;
      tick();
      check("rst_mid_req", 32'(b_mreq), 32'h0);
      check("rst_mid_busy", 32'(b_busy), 32'h0);
      rst = 1'b0;
      lat_b = 1;
      exp_mem_b.push_back('{addr: 16'h0A00, we: 1'b0, wdata: 16'h0000});
      exp_done_b.push_back('{done: 3'b001, err: 1'b0, rdata: 16'h050F});
      tick();
      check("rst_ptr_zero", 32'(b_maddr), 32'h0A00);
      tick();
      b_req = 3'b000;
      tick();
      tick();
      tick();

      check("a_done_queue_empty", 32'(exp_done_a.size()), 32'h0);
      check("b_done_queue_empty", 32'(exp_done_b.size()), 32'h0);
      check("mem_queues_empty", 32'(exp_mem_a.size() + exp_mem_b.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
